primogen_sched: RTL
===================

Name: primogen_sched

Overview:
- Sequences one primogen generator and shares its prime stream among NREQ requesters.
- Prefetches primes into a small FIFO ahead of demand, so a requester normally gets a prime one cycle after asking and does not wait the full divisor search.
- Sits beside primogen in the top level: drives its go, observes ready/error/res, and arbitrates grants round-robin.

Parameters:
- WIDTH_LOG, 4, log2 of prime width; WIDTH = 1 << WIDTH_LOG (must match primogen).
- NREQ, 4, number of requesters (2..8).
- DEPTH_LOG, 2, log2 of prefetch FIFO depth; DEPTH = 1 << DEPTH_LOG.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; the same rst drives primogen.
- req  in  NREQ  per-requester request level.
- grant  out  NREQ  one-hot, one-cycle pulse; the response is valid while it is high.
- res  out  WIDTH  prime delivered with grant.
- res_err  out  1  with grant: the generator has overflowed and no prime is available.
- gen_go  out  1  go pulse to primogen.
- gen_ready  in  1  primogen ready.
- gen_error  in  1  primogen error.
- gen_res  in  WIDTH  primogen result.
- fifo_level  out  DEPTH_LOG+1  current FIFO occupancy.

Behaviour:
- Reset:
  - grant=0, res=0, res_err=0, gen_go=0, fifo_level=0.
  - FIFO emptied, RR pointer=0, halt flag cleared, FSM=IDLE.
  - The primogen reset value (1) is never pushed, so the delivered stream starts at 2.
- Prefetch FSM, states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT:
  - IDLE: if fifo_level < DEPTH and gen_ready, go to ISSUE. Any simultaneous pop counts only from the next cycle.
  - ISSUE: gen_go=1 for exactly one cycle, then WAIT_BUSY.
  - WAIT_BUSY: wait for gen_ready=0, which primogen gives one cycle after go; then WAIT_DONE.
  - WAIT_DONE: on gen_ready=1:
    - if gen_error, set the sticky halt flag and go to HALT;
    - else push gen_res and return to IDLE.
  - HALT: gen_go is never asserted again until rst.
- FIFO rules:
  - A push can never find the FIFO full, because at most one generation is in flight and it starts only when there is space.
  - Simultaneous push and pop leave fifo_level unchanged and preserve order.
  - No bypass: a pushed value is grantable from the next cycle.
  - Pointers wrap modulo DEPTH.
- Arbiter, registered outputs:
  - Eligible request = req[i] AND NOT grant[i]. A requester's req is ignored in the cycle its grant is high, so one held req yields one grant per two cycles at most and never a duplicate.
  - If the FIFO is non-empty and any request is eligible: pick the first eligible index at or above the RR pointer, wrapping.
  - Next cycle: grant[idx]=1, res=FIFO head, res_err=0; pop; RR pointer = idx+1 mod NREQ.
  - If the halt flag is set and the FIFO is empty: the same pick yields grant with res=0, res_err=1, and no pop. Requesters are never deadlocked.
  - At most one grant per cycle. With no eligible request, grant=0 and res/res_err hold their previous values.
  - Requesters must hold req until they receive a grant. Dropping req early is legal and simply withdraws the request.
- Reset mid-operation (any state, including WAIT_DONE): everything returns to reset values at the next edge. The in-flight result is discarded; primogen is reset together with this block.
- Width: fifo_level saturates naturally at DEPTH; no arithmetic on prime values.

Decomposition:
- Shared header, alongside defines.vh: FSM state codes, and the assert macros used for the "push never when full" and "grant one-hot" checks.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH_LOG; push/pop/full/empty/level, registered head output).
- The arbiter and the FSM stay in primogen_sched.

Test Plan:
1. Reset, no req, DEPTH=4 → gen_go pulses four times; FIFO holds 2,3,5,7; fifo_level=4; gen_go stays 0 afterwards.
2. req[0] held continuously → grant[0] pulses on alternate cycles (paced by generator latency once the FIFO drains) with res 2,3,5,7,11,13 in order; no value skipped or repeated.
3. FIFO full, req=4'b1111 in one cycle and held → grants 0,1,2,3 in consecutive cycles with res 2,3,5,7; the next grant goes to requester 0.
4. WIDTH_LOG=3, req[1] held to exhaustion → last res=251, res_err=0; following grants have res_err=1, res=0; gen_go never asserts after gen_error.
5. rst pulsed while FSM=WAIT_DONE → all outputs 0 and fifo_level=0 next cycle; after release the first grant gives res=2.
6. fifo_level=1 with push and pop in the same cycle → fifo_level stays 1; the next grant returns the pushed value.

Source files
------------

// File: rtl/primogen_sched_pkg.sv
// primogen_sched_pkg
//   Shared definitions for the primogen prefetch scheduler.
//   state_t : prefetch FSM state codes (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT).
package primogen_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_HALT      = 3'd4
   } state_t;

endpackage

// File: rtl/primogen_sched_fifo.sv
// primogen_sched_fifo
//   Small synchronous FIFO holding prefetched primes. The storage array has a
//   registered read port; the read register always presents the current head,
//   so the consumer can use it in the same cycle it pops.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     push, push_data  write one entry (must not be asserted while full)
//     pop              remove the head entry (ignored while empty)
//     head             registered value of the oldest entry
//     full, empty      occupancy flags
//     level            number of entries held (0..DEPTH)
module primogen_sched_fifo
   import primogen_sched_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH_LOG = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [DEPTH_LOG-1:0]   rd_ptr_reg;
   logic [DEPTH_LOG-1:0]   wr_ptr_reg;
   logic [DEPTH_LOG:0]     level_reg;
   logic [WIDTH-1:0]       head_reg;

   logic                   do_pop;
   logic [DEPTH_LOG-1:0]   rd_ptr_next;
   logic [DEPTH_LOG:0]     remain;

   assign empty       = (level_reg == '0);
   assign full        = (level_reg == (DEPTH_LOG+1)'(DEPTH));
   assign do_pop      = pop && !empty;
   assign rd_ptr_next = rd_ptr_reg + DEPTH_LOG'(do_pop);
   // Entries left over from before this edge once the pop is taken; if none,
   // the head can only come from the value being pushed right now.
   assign remain      = level_reg - (DEPTH_LOG+1)'(do_pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         level_reg  <= '0;
         head_reg   <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG'(push);
         level_reg  <= level_reg + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(do_pop);
         // The slot at rd_ptr_next is never the one being written while
         // entries remain, so the old array contents are the right source.
         if (remain != '0) begin
            head_reg <= mem[rd_ptr_next];
         end else if (push) begin
            head_reg <= push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
      end
   end

   assign head  = head_reg;
   assign level = level_reg;

endmodule

// File: rtl/primogen_sched.sv
// primogen_sched
//   Drives one primogen generator to prefetch primes into a small FIFO and
//   hands them out round-robin to NREQ requesters.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (shared with primogen)
//     req           per-requester request level
//     grant         one-hot, one-cycle response strobe
//     res           prime delivered with grant
//     res_err       with grant: generator exhausted, no prime available
//     gen_go        go pulse to primogen
//     gen_ready     primogen ready
//     gen_error     primogen overflow error
//     gen_res       primogen result
//     fifo_level    prefetch FIFO occupancy
module primogen_sched
   import primogen_sched_pkg::*;
#(
   parameter int WIDTH_LOG = 4,
   parameter int NREQ      = 4,
   parameter int DEPTH_LOG = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   output logic [NREQ-1:0]            grant,
   output logic [(1<<WIDTH_LOG)-1:0]  res,
   output logic                       res_err,
   output logic                       gen_go,
   input  logic                       gen_ready,
   input  logic                       gen_error,
   input  logic [(1<<WIDTH_LOG)-1:0]  gen_res,
   output logic [DEPTH_LOG:0]         fifo_level
);

   localparam int WIDTH = 1 << WIDTH_LOG;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t             state_reg;
   logic               gen_go_reg;
   logic               halt_reg;

   logic [NREQ-1:0]    grant_reg;
   logic [WIDTH-1:0]   res_reg;
   logic               res_err_reg;
   logic [PTR_W-1:0]   rr_reg;

   logic               fifo_push;
   logic               fifo_pop;
   logic [WIDTH-1:0]   fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [DEPTH_LOG:0] fifo_level_int;

   logic [NREQ-1:0]    eligible;
   logic               found;
   logic [PTR_W-1:0]   pick_idx;

   // The reset value of primogen is never pushed: only completed searches
   // seen in WAIT_DONE reach the FIFO.
   assign fifo_push = (state_reg == ST_WAIT_DONE) && gen_ready && !gen_error;

   primogen_sched_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (gen_res),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level_int)
   );

   // Prefetch FSM: at most one generation in flight, started only while
   // there is room, so a push can never meet a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         gen_go_reg <= 1'b0;
         halt_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_full && gen_ready) begin
                  state_reg  <= ST_ISSUE;
                  gen_go_reg <= 1'b1;
               end
            end
            ST_ISSUE: begin
               gen_go_reg <= 1'b0;
               state_reg  <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!gen_ready) begin
                  state_reg <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (gen_ready) begin
                  if (gen_error) begin
                     halt_reg  <= 1'b1;
                     state_reg <= ST_HALT;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            ST_HALT: begin
               gen_go_reg <= 1'b0;
            end
            default: begin
               state_reg  <= ST_IDLE;
               gen_go_reg <= 1'b0;
            end
         endcase
      end
   end

   // A requester is ignored in the cycle its own grant is showing, so a held
   // req cannot be served twice for one request.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      assign eligible[gi] = req[gi] && !grant_reg[gi];
   end

   // Round-robin search starting at rr_reg, wrapping.
   always_comb begin
      int j;
      found    = 1'b0;
      pick_idx = '0;
      j        = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr_reg) + k) % NREQ;
         if (!found && eligible[j]) begin
            found    = 1'b1;
            pick_idx = PTR_W'(j);
         end
      end
   end

   assign fifo_pop = found && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_reg   <= '0;
         res_reg     <= '0;
         res_err_reg <= 1'b0;
         rr_reg      <= '0;
      end else begin
         grant_reg <= '0;
         if (found && (!fifo_empty || halt_reg)) begin
            grant_reg <= NREQ'(1) << pick_idx;
            rr_reg    <= (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + PTR_W'(1);
            if (!fifo_empty) begin
               res_reg     <= fifo_head;
               res_err_reg <= 1'b0;
            end else begin
               // Generator exhausted and nothing buffered: answer with an
               // error so no requester waits forever.
               res_reg     <= '0;
               res_err_reg <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(grant_reg));
      end
   end

   assign grant      = grant_reg;
   assign res        = res_reg;
   assign res_err    = res_err_reg;
   assign gen_go     = gen_go_reg;
   assign fifo_level = fifo_level_int;

endmodule
